// File: rtl/div_unit.sv
// Purpose : iterative restoring RV32M divider (DIV/DIVU/REM/REMU) for the EX stage.
// Latency : XLEN+1 cycles from accept to div_done; divide-by-zero / signed overflow in 1 cycle.
// Backpr. : div_en is held by the stall until div_done; dropping div_en mid-op kills the op.
// Ports   : clk, rst_n (async active-low); div_en/div_op/dividend/divisor in (sampled on accept);
//           result (registered, held until next completion), div_done (1-cycle pulse), busy.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            div_en,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] result,
    output logic            div_done,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              rem_sel_q, rem_sel_d;   // 1: REM/REMU, 0: DIV/DIVU
    logic              negq_q, negq_d;         // quotient needs negation
    logic              negr_q, negr_d;         // remainder needs negation
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;           // |divisor|
    logic [XLEN-1:0]   result_q, result_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Operand decode for the accept cycle
    logic              is_signed, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0]   a_abs, b_abs;

    // One restoring step
    logic [XLEN:0]     trial;
    logic              borrow, last_iter;
    logic [XLEN-1:0]   rem_next, quo_next, q_fix, r_fix;

    always_comb begin
        is_signed = ~div_op[0];
        a_neg     = is_signed & dividend[XLEN-1];
        b_neg     = is_signed & divisor[XLEN-1];
        a_abs     = a_neg ? -dividend : dividend;
        b_abs     = b_neg ? -divisor  : divisor;
        div_zero  = (divisor == '0);
        ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    end

    // The shifted partial remainder is kept XLEN+1 wide so an unsigned divisor
    // above 2^(XLEN-1) cannot lose the top remainder bit during the shift.
    always_comb begin
        trial     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};
        borrow    = trial[XLEN];
        rem_next  = borrow ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
        quo_next  = {quo_q[XLEN-2:0], ~borrow};
        q_fix     = negq_q ? -quo_next : quo_next;
        r_fix     = negr_q ? -rem_next : rem_next;
        last_iter = (cnt_q == CW'(XLEN - 1));
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (div_en) state_d = (div_zero || ovf) ? S_DONE : S_BUSY;
            S_BUSY: begin
                if (!div_en)        state_d = S_IDLE;   // instruction killed
                else if (last_iter) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        rem_sel_d = rem_sel_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        if (state_q == S_IDLE && div_en) begin
            rem_sel_d = div_op[1];
            negq_d    = a_neg ^ b_neg;
            negr_d    = a_neg;
            dvs_d     = b_abs;
            quo_d     = a_abs;
            rem_d     = '0;
            cnt_d     = '0;
            if (div_zero)
                result_d = div_op[1] ? dividend : '1;
            else if (ovf)
                result_d = div_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end else if (state_q == S_BUSY && div_en) begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
            if (last_iter)
                result_d = rem_sel_q ? r_fix : q_fix;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rem_sel_q <= 1'b0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rem_sel_q <= rem_sel_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs
    always_comb begin
        div_done = (state_q == S_DONE);
        busy     = (state_q == S_BUSY);
        result   = result_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Purpose : self-checking bench for div_unit (table vectors, random ops vs. arithmetic model,
//           back-to-back, abort and async-reset sequences).
// Latency : cycle 0 is the accept cycle; outputs are sampled on the falling edge.
// Backpr. : div_en is held high until div_done, as the hazard stall would do.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_en = 1'b0;
    logic [1:0]  div_op = 2'd0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] result;
    logic        div_done;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .div_en   (div_en),
        .div_op   (div_op),
        .dividend (dividend),
        .divisor  (divisor),
        .result   (result),
        .div_done (div_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endfunction

    // Reference: RISC-V M-extension semantics in plain integer arithmetic
    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'h0 : 32'h8000_0000;
        case (op)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, keep div_en high until div_done, scramble operands after accept.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int nbusy);
        @(posedge clk); #1;
        div_en = 1'b1; div_op = op; dividend = a; divisor = b;
        lat = -1; nbusy = 0; res = 'x;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (div_done) begin
                lat = c;
                res = result;
                break;
            end
            if (c >= 1) begin
                dividend = $urandom;
                divisor  = $urandom;
                div_op   = 2'($urandom);
            end
        end
        @(posedge clk); #1;
        div_en = 1'b0;
        @(negedge clk);
        check("no_double_pulse", {31'd0, div_done}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        int          lat;
        int          nbusy;
        int          elat;
        int          done_cyc[$];
        logic [31:0] done_res[$];
        int          npulse;

        add(2'd1, 32'd100,        32'd7,          32'd14,         33);
        add(2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
        add(2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
        add(2'd3, 32'd7,          32'd2,          32'd1,          33);
        add(2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  33);
        add(2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          33);
        add(2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        add(2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
        add(2'd2, 32'd5,          32'd0,          32'd5,          1);
        add(2'd3, 32'd5,          32'd0,          32'd5,          1);
        add(2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
        add(2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
        add(2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33);
        add(2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33);
        add(2'd3, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  33);
        add(2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33);
        add(2'd0, 32'h8000_0000,  32'd1,          32'h8000_0000,  33);

        // Reset state, sampled with reset asserted
        #12;
        check("reset_result", result, 32'd0);
        check("reset_done", {31'd0, div_done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, nbusy);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), (vecs[i].lat == 1) ? 32'd0 : 32'd32);
        end

        // Random ops against the arithmetic model
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          mode;
            op   = 2'($urandom);
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: begin a = $urandom_range(0, 200); b = $urandom_range(1, 300); end
                default: ;
            endcase
            exp  = ref_res(op, a, b);
            elat = ref_lat(op, a, b);
            run_op(op, a, b, res, lat, nbusy);
            check($sformatf("rand%0d_result op=%0d a=%h b=%h", i, op, a, b), res, exp);
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
        end

        // Back-to-back DIVU with div_en held high: 1000/10 then 81/9
        @(posedge clk); #1;
        div_en = 1'b1; div_op = 2'd1; dividend = 32'd1000; divisor = 32'd10;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (div_done) begin
                done_cyc.push_back(c);
                done_res.push_back(result);
                if (done_cyc.size() == 1) begin
                    dividend = 32'd81;
                    divisor  = 32'd9;
                end else begin
                    div_en = 1'b0;
                end
            end
        end
        div_en = 1'b0;
        repeat (40) @(negedge clk);
        check("b2b_pulse_count", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() == 2) begin
            check("b2b_first_cycle", 32'(done_cyc[0]), 32'd33);
            check("b2b_second_cycle", 32'(done_cyc[1]), 32'd67);
            check("b2b_first_result", done_res[0], 32'd100);
            check("b2b_second_result", done_res[1], 32'd9);
        end

        // Abort: div_en dropped in BUSY cycle 10
        exp = result;
        npulse = 0;
        @(posedge clk); #1;
        div_en = 1'b1; div_op = 2'd1; dividend = 32'd12345; divisor = 32'd7;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (div_done) npulse++;
            if (c == 10) begin
                check("abort_busy_c10", {31'd0, busy}, 32'd1);
                div_en = 1'b0;
            end
        end
        @(negedge clk);
        check("abort_busy_c11", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (div_done) npulse++;
        end
        check("abort_no_done", 32'(npulse), 32'd0);
        check("abort_result_held", result, exp);

        // Asynchronous reset in BUSY cycle 5 (previous result is nonzero)
        @(posedge clk); #1;
        div_en = 1'b1; div_op = 2'd1; dividend = 32'd99; divisor = 32'd5;
        repeat (6) @(negedge clk);
        check("rst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        check("rst_async_done", {31'd0, div_done}, 32'd0);
        check("rst_async_result", result, 32'd0);
        div_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Recovery after reset
        run_op(2'd1, 32'd81, 32'd9, res, lat, nbusy);
        check("post_rst_result", res, 32'd9);
        check("post_rst_latency", 32'(lat), 32'd33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
